axi_lite_req_arbiter: RTL and testbench

- Shares one AXI-Lite master user interface between two requesters: port 0 is the PCIe RX target engine and port 1 is the local config/init sequencer.
- Grants requests round-robin and sequences the rd_en/wr_en level-then-release protocol the master expects (it edge-detects enables).
- Holds address, strobes and data stable for the whole transaction.
- Enforces a completion timeout and returns an error word on expiry.

---
 rtl/axi_lite_req_arbiter_if.sv | 51 +++++
 rtl/axi_lite_req_arbiter.sv | 159 +++++++++++++++
 tb/tb_axi_lite_req_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_req_arbiter_if.sv
// Requester-side and AXI-Lite-master-side signals of the two-port request arbiter.
// The arbiter uses the master modport; the requesters and the AXI-Lite master sit behind slave.
interface axi_lite_req_arbiter_if;
    // requester 0: PCIe RX target engine
    logic        req0_valid;
    logic        req0_we;
    logic [31:0] req0_addr;
    logic [3:0]  req0_be;
    logic [31:0] req0_wdata;
    logic        req0_done;
    logic        req0_err;

    // requester 1: local config/init sequencer
    logic        req1_valid;
    logic        req1_we;
    logic [31:0] req1_addr;
    logic [3:0]  req1_be;
    logic [31:0] req1_wdata;
    logic        req1_done;
    logic        req1_err;

    logic [31:0] req_rdata;

    // AXI-Lite master user side
    logic [31:0] rd_addr;
    logic [3:0]  rd_be;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic [31:0] wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_done;

    modport master (
        input  req0_valid, req0_we, req0_addr, req0_be, req0_wdata,
               req1_valid, req1_we, req1_addr, req1_be, req1_wdata,
               rd_data, rd_data_valid, wr_done,
        output req0_done, req0_err, req1_done, req1_err, req_rdata,
               rd_addr, rd_be, rd_en, wr_addr, wr_be, wr_data, wr_en
    );

    modport slave (
        output req0_valid, req0_we, req0_addr, req0_be, req0_wdata,
               req1_valid, req1_we, req1_addr, req1_be, req1_wdata,
               rd_data, rd_data_valid, wr_done,
        input  req0_done, req0_err, req1_done, req1_err, req_rdata,
               rd_addr, rd_be, rd_en, wr_addr, wr_be, wr_data, wr_en
    );
endinterface

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin sharing of one AXI-Lite master user interface between two requesters,
// with level-then-release enables, stable request fields and a completion timeout.
module axi_lite_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hBADFEED0
) (
    input  logic                   M_AXI_ACLK,
    input  logic                   M_AXI_ARESET,
    axi_lite_req_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    // per-port request view, indexable by the grant
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [31:0] req_addr  [2];
    logic [3:0]  req_be    [2];
    logic [31:0] req_wdata [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_valid[gi] = (gi == 0) ? bus.req0_valid : bus.req1_valid;
        assign req_we[gi]    = (gi == 0) ? bus.req0_we    : bus.req1_we;
        assign req_addr[gi]  = (gi == 0) ? bus.req0_addr  : bus.req1_addr;
        assign req_be[gi]    = (gi == 0) ? bus.req0_be    : bus.req1_be;
        assign req_wdata[gi] = (gi == 0) ? bus.req0_wdata : bus.req1_wdata;
    end

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;          // port preferred when both request
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        sel;
    logic        rsp_hit;
    logic        tmo_hit;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        done_d  = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        sel     = 1'b0;
        rsp_hit = 1'b0;
        tmo_hit = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    sel     = (&req_valid) ? ptr_q : req_valid[1];
                    gnt_d   = sel;
                    ptr_d   = ~sel;
                    we_d    = req_we[sel];
                    addr_d  = req_addr[sel];
                    be_d    = req_be[sel];
                    wdata_d = req_wdata[sel];
                    cnt_d   = '0;
                    rd_en_d = ~req_we[sel];
                    wr_en_d = req_we[sel];
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // a response of the other type is not ours and is ignored
                rsp_hit = we_q ? bus.wr_done : bus.rd_data_valid;
                tmo_hit = (cnt_q == CNT_LAST);
                cnt_d   = cnt_q + 16'd1;
                rd_en_d = rd_en_q;
                wr_en_d = wr_en_q;
                if (rsp_hit || tmo_hit) begin
                    rd_en_d       = 1'b0;
                    wr_en_d       = 1'b0;
                    done_d[gnt_q] = 1'b1;
                    err_d[gnt_q]  = ~rsp_hit;
                    if (!rsp_hit) begin
                        rdata_d = ERR_RDATA;
                    end else if (!we_q) begin
                        rdata_d = bus.rd_data;
                    end
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req0_done = done_q[0];
    assign bus.req1_done = done_q[1];
    assign bus.req0_err  = err_q[0];
    assign bus.req1_err  = err_q[1];
    assign bus.req_rdata = rdata_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_addr   = addr_q;
    assign bus.wr_addr   = addr_q;
    assign bus.rd_be     = be_q;
    assign bus.wr_be     = be_q;
    assign bus.wr_data   = wdata_q;
endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Bench for axi_lite_req_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_axi_lite_req_arbiter;
    localparam int          TMO = 16;
    localparam logic [31:0] ERR = 32'hBADFEED0;

    logic clk;
    logic rst;
    axi_lite_req_arbiter_if bus();

    axi_lite_req_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)) dut (
        .M_AXI_ACLK  (clk),
        .M_AXI_ARESET(rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } rec_t;
    rec_t done_log[$];
    int   en_runs[$];

    // responder controls
    int          resp_delay = 0;      // BUSY cycle carrying the response; 0 = never
    int          resp_kind  = 0;      // 1 = wrong-type pulse first, correct one 2 cycles later
    logic [31:0] resp_data  = '0;
    int          late_req   = 0;
    int          late_ack   = 0;
    int          hi_cnt     = 0;

    // reference model: who owns the bus, for how long, and what was last delivered
    int          m_owner = -1;
    bit          m_gap   = 0;
    int          m_age   = 0;
    int          m_pref  = 0;
    bit          m_we    = 0;
    logic [31:0] m_addr  = '0;
    logic [3:0]  m_be    = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    bit          m_done0 = 0;
    bit          m_done1 = 0;
    bit          m_err   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_gap = 0; m_age = 0; m_pref = 0; m_we = 0;
            m_addr = '0; m_be = '0; m_wdata = '0; m_rdata = '0;
            m_done0 = 0; m_done1 = 0; m_err = 0;
        end else if (m_gap) begin
            m_gap = 0; m_done0 = 0; m_done1 = 0; m_err = 0;
        end else if (m_owner >= 0) begin
            m_age++;
            if ((m_we && bus.wr_done) || (!m_we && bus.rd_data_valid) || m_age == TMO) begin
                m_err = !((m_we && bus.wr_done) || (!m_we && bus.rd_data_valid));
                if (m_err) m_rdata = ERR;
                else if (!m_we) m_rdata = bus.rd_data;
                if (m_owner == 0) m_done0 = 1; else m_done1 = 1;
                m_owner = -1;
                m_gap   = 1;
            end
        end else if (bus.req0_valid || bus.req1_valid) begin
            if (bus.req0_valid && bus.req1_valid) m_owner = m_pref;
            else m_owner = bus.req0_valid ? 0 : 1;
            m_pref = 1 - m_owner;
            m_age  = 0;
            m_we    = (m_owner == 0) ? bus.req0_we    : bus.req1_we;
            m_addr  = (m_owner == 0) ? bus.req0_addr  : bus.req1_addr;
            m_be    = (m_owner == 0) ? bus.req0_be    : bus.req1_be;
            m_wdata = (m_owner == 0) ? bus.req0_wdata : bus.req1_wdata;
        end
    end

    // response generator standing in for the AXI-Lite master
    always @(posedge clk) begin
        #1;
        bus.rd_data_valid = 1'b0;
        bus.wr_done       = 1'b0;
        if (bus.rd_en || bus.wr_en) begin
            hi_cnt++;
            if (resp_delay != 0 && ((resp_kind == 0 && hi_cnt == resp_delay) ||
                                    (resp_kind == 1 && hi_cnt == resp_delay + 2))) begin
                if (bus.rd_en) begin
                    bus.rd_data       = resp_data;
                    bus.rd_data_valid = 1'b1;
                end else begin
                    bus.wr_done = 1'b1;
                end
            end else if (resp_delay != 0 && resp_kind == 1 && hi_cnt == resp_delay) begin
                if (bus.rd_en) bus.wr_done = 1'b1;
                else begin
                    bus.rd_data       = 32'h0BAD_0BAD;
                    bus.rd_data_valid = 1'b1;
                end
            end
        end else begin
            hi_cnt = 0;
            if (late_req != late_ack) begin
                late_ack          = late_req;
                bus.rd_data       = 32'hDEAD_0000;
                bus.rd_data_valid = 1'b1;
            end
        end
    end

    task automatic compare_loop();
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            chk("rd_en",     32'(bus.rd_en),     32'(m_owner >= 0 && !m_we));
            chk("wr_en",     32'(bus.wr_en),     32'(m_owner >= 0 && m_we));
            chk("req0_done", 32'(bus.req0_done), 32'(m_done0));
            chk("req1_done", 32'(bus.req1_done), 32'(m_done1));
            chk("req0_err",  32'(bus.req0_err),  32'(m_done0 && m_err));
            chk("req1_err",  32'(bus.req1_err),  32'(m_done1 && m_err));
            chk("req_rdata", bus.req_rdata, m_rdata);
            chk("rd_addr",   bus.rd_addr,   m_addr);
            chk("wr_addr",   bus.wr_addr,   m_addr);
            chk("rd_be",     32'(bus.rd_be), 32'(m_be));
            chk("wr_be",     32'(bus.wr_be), 32'(m_be));
            chk("wr_data",   bus.wr_data,   m_wdata);
            chk("en_excl",   32'(bus.rd_en & bus.wr_en), 32'd0);
            if (bus.req0_done || bus.req1_done) begin
                rec_t r;
                r.port  = bus.req0_done ? 0 : 1;
                r.err   = bus.req0_done ? bus.req0_err : bus.req1_err;
                r.rdata = bus.req_rdata;
                done_log.push_back(r);
                $display("[TB] done port %0d err %0b rdata %h", r.port, r.err, r.rdata);
            end
            if (bus.rd_en || bus.wr_en) run++;
            else if (run > 0) begin
                en_runs.push_back(run);
                run = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a;
            bus.req0_be = be; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a;
            bus.req1_be = be; bus.req1_wdata = d;
        end
    endtask

    task automatic wait_done(input int p);
        for (int i = 0; i < 100; i++) begin
            if ((p == 0 && bus.req0_done) || (p == 1 && bus.req1_done)) return;
            tick();
        end
        n_tests++;
        n_fail++;
        $display("[TB] FAIL done_wait port %0d: got no done, expected one within 100 cycles", p);
    endtask

    // raise a request, hold it until done, drop it in the following cycle
    task automatic run_req(input int p, input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        set_req(p, 1'b1, we, a, be, d);
        tick();
        wait_done(p);
        tick();
        set_req(p, 1'b0, we, a, be, d);
    endtask

    task automatic port_seq(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            run_req(p, logic'(p), 32'h4000_0100 + 32'(p * 16 + k), 4'hF, 32'h1000_0000 + 32'(k));
            tick();
        end
    endtask

    task automatic stimulus();
        int base;
        repeat (3) tick();
        chk("reset_rdata", bus.req_rdata, 32'd0);
        chk("reset_rd_en", 32'(bus.rd_en), 32'd0);
        rst = 1'b0;
        tick();

        // single read, port 0, response in 4th BUSY cycle
        resp_delay = 4; resp_kind = 0; resp_data = 32'h1234_5678;
        run_req(0, 1'b0, 32'h4000_0010, 4'hF, 32'h0);
        tick();
        chk("t1_port",  32'(done_log[$].port), 32'd0);
        chk("t1_err",   32'(done_log[$].err),  32'd0);
        chk("t1_rdata", done_log[$].rdata, 32'h1234_5678);
        chk("t1_run",   32'(en_runs[$]), 32'd4);

        // single write, port 1
        resp_delay = 6;
        run_req(1, 1'b1, 32'h8000_0020, 4'hC, 32'hA5A5_0001);
        tick();
        chk("t2_port",  32'(done_log[$].port), 32'd1);
        chk("t2_err",   32'(done_log[$].err),  32'd0);
        chk("t2_rdata", done_log[$].rdata, 32'h1234_5678);
        chk("t2_run",   32'(en_runs[$]), 32'd6);

        // both ports continuously busy from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = done_log.size();
        resp_delay = 2; resp_data = 32'h5555_AAAA;
        fork
            port_seq(0, 4);
            port_seq(1, 4);
        join
        tick();
        chk("t3_count", 32'(done_log.size() - base), 32'd8);
        for (int k = 0; k < 8 && base + k < done_log.size(); k++)
            chk("t3_order", 32'(done_log[base + k].port), 32'(k % 2));

        // read timeout, then a stray late response
        resp_delay = 0;
        run_req(0, 1'b0, 32'h4000_0030, 4'h3, 32'h0);
        tick();
        chk("t4_err",   32'(done_log[$].err), 32'd1);
        chk("t4_rdata", done_log[$].rdata, ERR);
        chk("t4_run",   32'(en_runs[$]), 32'(TMO));
        late_req++;
        repeat (3) tick();
        chk("t4_late_rdata", bus.req_rdata, ERR);

        // response coincides with timeout: data wins
        resp_delay = TMO; resp_data = 32'hCAFE_0005;
        run_req(1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
        tick();
        chk("t5_err",   32'(done_log[$].err), 32'd0);
        chk("t5_rdata", done_log[$].rdata, 32'hCAFE_0005);
        chk("t5_run",   32'(en_runs[$]), 32'(TMO));

        // wrong-type pulse ignored during a read
        resp_delay = 2; resp_kind = 1; resp_data = 32'h0600_0006;
        run_req(0, 1'b0, 32'h4000_0060, 4'hF, 32'h0);
        tick();
        chk("t6_rdata", done_log[$].rdata, 32'h0600_0006);
        chk("t6_run",   32'(en_runs[$]), 32'd4);

        // reset on 2nd BUSY cycle of a port 0 write
        resp_delay = 0; resp_kind = 0; resp_data = 32'h0700_0007;
        set_req(0, 1'b1, 1'b1, 32'h4000_0070, 4'h5, 32'h7777_0000);
        for (int i = 0; i < 20 && !bus.wr_en; i++) tick();
        tick();
        base = done_log.size();
        rst = 1'b1;
        set_req(1, 1'b1, 1'b0, 32'h8000_0070, 4'hF, 32'h0);
        tick();
        chk("t7_wr_en_drop", 32'(bus.wr_en), 32'd0);
        rst = 1'b0;
        resp_delay = 3;
        wait_done(0);
        tick();
        set_req(0, 1'b0, 1'b1, 32'h4000_0070, 4'h5, 32'h7777_0000);
        wait_done(1);
        tick();
        set_req(1, 1'b0, 1'b0, 32'h8000_0070, 4'hF, 32'h0);
        tick();
        chk("t7_count", 32'(done_log.size() - base), 32'd2);
        if (done_log.size() >= base + 2) begin
            chk("t7_first", 32'(done_log[base].port), 32'd0);
            chk("t7_second", 32'(done_log[base + 1].port), 32'd1);
        end
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.rd_data = '0; bus.rd_data_valid = 1'b0; bus.wr_done = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        fork
            stimulus();
            compare_loop();
            begin
                #200000;
                n_tests++;
                n_fail++;
                $display("[TB] FAIL watchdog: got no completion of stimulus, expected finish before 200000");
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
